spi_slave_frame: RTL and testbench

- Synthesizable SPI slave frame engine, i.e. the sensor-side DUT whose sclk/mosi/miso/csb pins the bench SPI monitor observes.
- Oversamples SPI pins in the system clock domain; assembles command frames; checks and generates the XOR-mask CRC.
- Drives a simple register bus and command strobes; returns status, measurement and register data on miso.

---
 rtl/spi_pkg.sv | 59 +++++
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_slave_frame.sv | 206 ++++++++++++++++++++
 tb/tb_spi_slave_frame.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave frame engine and its monitor:
// command codes, status byte layout, CRC defaults and per-command frame geometry.
package spi_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned MEAS_W = 24;

  localparam logic [7:0] CRC_POLY_DEF  = 8'h2F;
  localparam logic [7:0] CRC_INIT_DEF  = 8'hFF;
  localparam logic [7:0] CRC_FINAL_DEF = 8'hFF;

  localparam logic [7:0] CMD_X10  = 8'h10;
  localparam logic [7:0] CMD_X20  = 8'h20;
  localparam logic [7:0] CMD_X30  = 8'h30;
  localparam logic [7:0] CMD_MEAS = 8'h40;
  localparam logic [7:0] CMD_WR   = 8'h50;
  localparam logic [7:0] CMD_RD   = 8'h60;
  localparam logic [7:0] CMD_XF0  = 8'hF0;

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_FINISH} state_e;

  typedef struct packed {
    logic [1:0] mode;
    logic [2:0] counter;
    logic       error;
    logic       warning;
    logic       drdy;
  } st_status;

  // Index of the received CRC byte; 0 marks an unknown command.
  function automatic logic [CNT_W-1:0] rx_crc_pos(input logic [BYTE_W-1:0] cmd);
    case (cmd)
      CMD_X10, CMD_X20, CMD_X30, CMD_MEAS, CMD_WR: return 4'd3;
      CMD_RD:  return 4'd2;
      CMD_XF0: return 4'd1;
      default: return 4'd0;
    endcase
  endfunction

  // Index of the transmitted CRC byte; 0 marks an unknown command.
  function automatic logic [CNT_W-1:0] tx_crc_pos(input logic [BYTE_W-1:0] cmd);
    case (cmd)
      CMD_X10, CMD_X20, CMD_X30: return 4'd5;
      CMD_MEAS: return 4'd4;
      CMD_WR:   return 4'd6;
      CMD_RD:   return 4'd4;
      CMD_XF0:  return 4'd3;
      default:  return 4'd0;
    endcase
  endfunction

  function automatic logic [BYTE_W-1:0] crc_step(input logic [BYTE_W-1:0] crc,
                                                 input logic [BYTE_W-1:0] data,
                                                 input logic [BYTE_W-1:0] poly);
    return crc ^ (data & poly);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin with registered edge pulses.
// Ports: clk, rst (sync, active high), d (async pin), rise/fall (one-clk pulses,
// STAGES+1 clk after the pin toggles).
module spi_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              level;

  // Chain resets low so a pin already low at reset release never yields a fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync  <= {sync[STAGES-2:0], d};
      level <= sync[STAGES-1];
      rise  <= sync[STAGES-1] & ~level;
      fall  <= ~sync[STAGES-1] & level;
    end
  end

endmodule

// File: rtl/spi_slave_frame.sv
// SPI mode-0 slave frame engine, oversampled in the clk domain.
// Ports: clk/rst; SPI pins sclk, mosi, csb in and miso/miso_oe out;
// status_i, meas_data sources for the tx frame; register bus reg_addr/reg_wdata/
// reg_wr/reg_rd/reg_rdata; command strobe cmd_valid/cmd_code; error pulses
// crc_err and frame_err.
module spi_slave_frame
  import spi_pkg::*;
#(
  parameter logic [7:0]  CRC_POLY    = CRC_POLY_DEF,
  parameter logic [7:0]  CRC_INIT    = CRC_INIT_DEF,
  parameter logic [7:0]  CRC_FINAL   = CRC_FINAL_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        csb,
  output logic        miso,
  output logic        miso_oe,
  input  logic [7:0]  status_i,
  input  logic [23:0] meas_data,
  output logic [7:0]  reg_addr,
  output logic [7:0]  reg_wdata,
  output logic        reg_wr,
  output logic        reg_rd,
  input  logic [7:0]  reg_rdata,
  output logic        cmd_valid,
  output logic [7:0]  cmd_code,
  output logic        crc_err,
  output logic        frame_err
);

  logic sclk_rise, sclk_fall, csb_rise, csb_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk(clk), .rst(rst), .d(sclk), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_csb_sync (
    .clk(clk), .rst(rst), .d(csb), .rise(csb_rise), .fall(csb_fall)
  );

  // One extra flop keeps mosi aligned with the registered sclk edge pulse.
  logic [SYNC_STAGES:0] mosi_sync;
  logic                 mosi_q;
  assign mosi_q = mosi_sync[SYNC_STAGES];

  state_e              state;
  logic [6:0]          rx_shift;
  logic [6:0]          tx_shift;
  logic [2:0]          bit_cnt;
  logic [CNT_W-1:0]    byte_cnt;
  logic [BYTE_W-1:0]   cmd;
  logic [BYTE_W-1:0]   rx_crc;
  logic [BYTE_W-1:0]   tx_crc;
  logic [BYTE_W-1:0]   rx_crc_byte;
  logic [BYTE_W-1:0]   rdata_q;
  logic [MEAS_W-1:0]   meas_q;
  logic                load_pend;
  logic                rd_cap;

  logic [BYTE_W-1:0]   rx_byte_c;
  logic [BYTE_W-1:0]   tx_next_c;
  logic [CNT_W-1:0]    rx_pos_c;
  logic [CNT_W-1:0]    tx_pos_c;
  logic [CNT_W-1:0]    cmd_pos_c;

  assign rx_byte_c = {rx_shift, mosi_q};
  // While byte0 completes the command is the byte being assembled.
  assign rx_pos_c  = rx_crc_pos((byte_cnt == 4'd0) ? rx_byte_c : cmd);
  assign tx_pos_c  = tx_crc_pos(cmd);
  assign cmd_pos_c = rx_crc_pos(cmd);

  // Tx map: payload of byte[byte_cnt] for the current command.
  always_comb begin
    tx_next_c = 8'h00;
    if (tx_pos_c != 4'd0 && byte_cnt == tx_pos_c) begin
      tx_next_c = tx_crc ^ CRC_FINAL;
    end else if (byte_cnt < tx_pos_c) begin
      case (cmd)
        CMD_MEAS: begin
          if (byte_cnt == 4'd1) tx_next_c = meas_q[23:16];
          if (byte_cnt == 4'd2) tx_next_c = meas_q[15:8];
          if (byte_cnt == 4'd3) tx_next_c = meas_q[7:0];
        end
        CMD_WR: begin
          if (byte_cnt == 4'd4) tx_next_c = reg_addr;
          if (byte_cnt == 4'd5) tx_next_c = reg_wdata;
        end
        CMD_RD: begin
          if (byte_cnt == 4'd3) tx_next_c = rdata_q;
        end
        default: tx_next_c = 8'h00;
      endcase
    end
  end

  // Frame FSM with shifters, CRCs and registered strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      mosi_sync   <= '0;
      state       <= ST_IDLE;
      rx_shift    <= '0;
      tx_shift    <= '0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      cmd         <= '0;
      rx_crc      <= '0;
      tx_crc      <= '0;
      rx_crc_byte <= '0;
      rdata_q     <= '0;
      meas_q      <= '0;
      load_pend   <= 1'b0;
      rd_cap      <= 1'b0;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      reg_wr      <= 1'b0;
      reg_rd      <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_code    <= '0;
      crc_err     <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      mosi_sync <= {mosi_sync[SYNC_STAGES-1:0], mosi};
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      cmd_valid <= 1'b0;
      crc_err   <= 1'b0;
      frame_err <= 1'b0;
      // Read data is valid the cycle after the reg_rd strobe.
      rd_cap    <= reg_rd;
      if (rd_cap) rdata_q <= reg_rdata;

      case (state)
        ST_IDLE: begin
          if (csb_fall) begin
            state       <= ST_ACTIVE;
            tx_shift    <= status_i[6:0];
            miso        <= status_i[7];
            miso_oe     <= 1'b1;
            meas_q      <= meas_data;
            rx_crc      <= CRC_INIT;
            tx_crc      <= crc_step(CRC_INIT, status_i, CRC_POLY);
            rx_shift    <= '0;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            cmd         <= '0;
            rx_crc_byte <= '0;
            load_pend   <= 1'b0;
          end
        end

        ST_ACTIVE: begin
          if (csb_rise) begin
            state   <= ST_FINISH;
            miso    <= 1'b0;
            miso_oe <= 1'b0;
          end else if (sclk_rise) begin
            rx_shift <= rx_byte_c[6:0];
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              load_pend <= 1'b1;
              if (byte_cnt != 4'hF) byte_cnt <= byte_cnt + 4'd1;
              if (byte_cnt == 4'd0) cmd <= rx_byte_c;
              if (byte_cnt < rx_pos_c) rx_crc <= crc_step(rx_crc, rx_byte_c, CRC_POLY);
              else if (byte_cnt == rx_pos_c) rx_crc_byte <= rx_byte_c;
              if ((cmd == CMD_WR || cmd == CMD_RD) && byte_cnt == 4'd1) reg_addr <= rx_byte_c;
              if (cmd == CMD_RD && byte_cnt == 4'd1) reg_rd <= 1'b1;
              if (cmd == CMD_WR && byte_cnt == 4'd2) reg_wdata <= rx_byte_c;
            end
          end else if (sclk_fall) begin
            if (load_pend) begin
              load_pend <= 1'b0;
              tx_shift  <= tx_next_c[6:0];
              miso      <= tx_next_c[7];
              if (byte_cnt < tx_pos_c) tx_crc <= crc_step(tx_crc, tx_next_c, CRC_POLY);
            end else begin
              tx_shift <= {tx_shift[5:0], 1'b0};
              miso     <= tx_shift[6];
            end
          end
        end

        ST_FINISH: begin
          state <= ST_IDLE;
          if (cmd_pos_c == 4'd0 || byte_cnt <= cmd_pos_c) begin
            frame_err <= 1'b1;
          end else if ((rx_crc ^ CRC_FINAL) != rx_crc_byte) begin
            crc_err <= 1'b1;
          end else if (cmd == CMD_WR) begin
            reg_wr <= 1'b1;
          end else if (cmd != CMD_RD) begin
            cmd_valid <= 1'b1;
            cmd_code  <= cmd;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_frame.sv
// Self-checking bench for spi_slave_frame: a bit-banged SPI master, a register
// bus slave, a table of directed frames, a reset-mid-frame sequence and random frames.
module tb_spi_slave_frame;

  localparam logic [7:0] POLY  = 8'h2F;
  localparam logic [7:0] INIT  = 8'hFF;
  localparam logic [7:0] FINAL = 8'hFF;

  logic        clk = 1'b0;
  logic        rst, sclk, mosi, csb, miso, miso_oe;
  logic [7:0]  status_i, reg_addr, reg_wdata, reg_rdata, cmd_code;
  logic [23:0] meas_data;
  logic        reg_wr, reg_rd, cmd_valid, crc_err, frame_err;

  always #5 clk = ~clk;

  spi_slave_frame dut (
    .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .csb(csb),
    .miso(miso), .miso_oe(miso_oe), .status_i(status_i), .meas_data(meas_data),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_rdata(reg_rdata), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .crc_err(crc_err), .frame_err(frame_err)
  );

  int n_cmp = 0, n_bad = 0;
  int n_wr = 0, n_val = 0, n_ce = 0, n_fe = 0, n_rd = 0;
  logic [7:0] last_wa, last_wd, last_code;
  logic [7:0] regmem [256];
  logic [7:0] shadow [256];

  function automatic logic [7:0] init_val(input int i);
    return (i == 32'h34) ? 8'h5C : 8'(i * 37 + 5);
  endfunction

  assign reg_rdata = regmem[reg_addr];

  // Bus slave and strobe monitor.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) regmem[i] = init_val(i);
    end else begin
      if (reg_wr) begin
        n_wr++; last_wa = reg_addr; last_wd = reg_wdata; regmem[reg_addr] = reg_wdata;
      end
      if (cmd_valid) begin n_val++; last_code = cmd_code; end
      if (crc_err) n_ce++;
      if (frame_err) n_fe++;
      if (reg_rd) n_rd++;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int rx_pos_m(input logic [7:0] c);
    case (c)
      8'h10, 8'h20, 8'h30, 8'h40, 8'h50: return 3;
      8'h60: return 2;
      8'hF0: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int tx_pos_m(input logic [7:0] c);
    case (c)
      8'h10, 8'h20, 8'h30: return 5;
      8'h40: return 4;
      8'h50: return 6;
      8'h60: return 4;
      8'hF0: return 3;
      default: return 0;
    endcase
  endfunction

  // Expected CRC byte over the first n bytes of a frame.
  function automatic logic [7:0] crc_of(input logic [7:0] b [20], input int n);
    logic [7:0] c = INIT;
    for (int i = 0; i < n; i++) c = c ^ (b[i] & POLY);
    return c ^ FINAL;
  endfunction

  function automatic logic [31:0] outs_vec();
    return {1'b0, miso, miso_oe, reg_wr, reg_rd, cmd_valid, crc_err, frame_err,
            reg_addr, reg_wdata, cmd_code};
  endfunction

  task automatic init_shadow();
    for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
  endtask

  task automatic xfer_byte(input logic [7:0] b, input int nbits, output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = b[3'(7 - i)];
      #30;
      got[3'(7 - i)] = miso;
      sclk = 1'b1;
      #60;
      sclk = 1'b0;
      #30;
    end
  endtask

  task automatic run_frame(input string tag, input logic [7:0] c, input logic [7:0] a,
                           input logic [7:0] d, input logic [7:0] st, input logic [23:0] ms,
                           input int nb, input int pb, input bit corrupt,
                           input bit e_wr, input bit e_val, input bit e_ce, input bit e_fe);
    logic [7:0] rxb [20];
    logic [7:0] txe [20];
    logic [7:0] g;
    int rp, tp, w0, v0, c0, f0, r0;
    bit e_rd;
    rp = rx_pos_m(c);
    tp = tx_pos_m(c);
    for (int i = 0; i < 20; i++) begin rxb[i] = 8'($urandom); txe[i] = 8'h00; end
    rxb[0] = c; rxb[1] = a; rxb[2] = d;
    if (rp != 0) rxb[rp] = crc_of(rxb, rp) ^ (corrupt ? 8'h01 : 8'h00);
    txe[0] = st;
    if (tp != 0) begin
      if (c == 8'h40) begin txe[1] = ms[23:16]; txe[2] = ms[15:8]; txe[3] = ms[7:0]; end
      if (c == 8'h50) begin txe[4] = a; txe[5] = d; end
      if (c == 8'h60) txe[3] = shadow[a];
      txe[tp] = crc_of(txe, tp);
    end
    e_rd = (c == 8'h60) && (nb >= 2);
    w0 = n_wr; v0 = n_val; c0 = n_ce; f0 = n_fe; r0 = n_rd;

    status_i = st; meas_data = ms;
    csb = 1'b0;
    #80;
    meas_data = ~ms;
    check($sformatf("%s miso_oe", tag), 32'(miso_oe), 32'd1);
    for (int i = 0; i < nb; i++) begin
      xfer_byte(rxb[i], 8, g);
      check($sformatf("%s miso[%0d]", tag, i), 32'(g), 32'(txe[i]));
    end
    if (pb > 0) xfer_byte(rxb[nb], pb, g);
    #80;
    csb = 1'b1;
    #150;

    check($sformatf("%s reg_wr", tag), 32'(n_wr - w0), 32'(e_wr));
    check($sformatf("%s cmd_valid", tag), 32'(n_val - v0), 32'(e_val));
    check($sformatf("%s crc_err", tag), 32'(n_ce - c0), 32'(e_ce));
    check($sformatf("%s frame_err", tag), 32'(n_fe - f0), 32'(e_fe));
    check($sformatf("%s reg_rd", tag), 32'(n_rd - r0), 32'(e_rd));
    if (e_wr) begin
      check($sformatf("%s wr addr/data", tag), 32'({last_wa, last_wd}), 32'({a, d}));
      shadow[a] = d;
    end
    if (e_val) check($sformatf("%s cmd_code", tag), 32'(last_code), 32'(c));
  endtask

  typedef struct {
    logic [7:0]  cmd, addr, data, st;
    logic [23:0] ms;
    int          nb, pb;
    bit          corrupt, wr, val, ce, fe;
  } vec_t;

  vec_t       tbl [14];
  logic [7:0] cmd_list [8];
  logic [7:0] g, rc;
  int         rp, nb, pb;
  bit         cor, comp;

  initial begin
    //           cmd    addr   data   st     meas        nb pb cor wr val ce fe
    tbl[0]  = '{8'h50, 8'h12, 8'hA5, 8'h81, 24'h000000, 7, 0, 0, 1, 0, 0, 0};
    tbl[1]  = '{8'h60, 8'h34, 8'h00, 8'h00, 24'h000000, 5, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{8'h40, 8'h00, 8'h00, 8'h02, 24'hABCDEF, 5, 0, 0, 0, 1, 0, 0};
    tbl[3]  = '{8'h50, 8'h12, 8'h3B, 8'h81, 24'h000000, 7, 0, 1, 0, 0, 1, 0};
    tbl[4]  = '{8'h20, 8'h01, 8'h02, 8'h11, 24'h000000, 2, 0, 0, 0, 0, 0, 1};
    tbl[5]  = '{8'h77, 8'h01, 8'h02, 8'h44, 24'h000000, 4, 0, 0, 0, 0, 0, 1};
    tbl[6]  = '{8'h30, 8'h9A, 8'hBC, 8'hE7, 24'h000000, 4, 0, 0, 0, 1, 0, 0};
    tbl[7]  = '{8'h10, 8'h5A, 8'hC3, 8'h6D, 24'h000000, 18, 0, 0, 0, 1, 0, 0};
    tbl[8]  = '{8'hF0, 8'h00, 8'h00, 8'hFF, 24'h000000, 2, 3, 0, 0, 1, 0, 0};
    tbl[9]  = '{8'h60, 8'h12, 8'h00, 8'h08, 24'h000000, 4, 0, 0, 0, 0, 0, 0};
    tbl[10] = '{8'h60, 8'h21, 8'h00, 8'h08, 24'h000000, 2, 0, 0, 0, 0, 0, 1};
    tbl[11] = '{8'h40, 8'h00, 8'h00, 8'h55, 24'h123456, 3, 5, 0, 0, 0, 0, 1};
    tbl[12] = '{8'hF0, 8'h00, 8'h00, 8'hA0, 24'h000000, 1, 0, 0, 0, 0, 0, 1};
    tbl[13] = '{8'h50, 8'h55, 8'h3C, 8'h42, 24'h000000, 4, 0, 0, 1, 0, 0, 0};
    cmd_list = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'hF0, 8'h77};

    rst = 1'b1; csb = 1'b1; sclk = 1'b0; mosi = 1'b0;
    status_i = 8'h00; meas_data = 24'h0;
    repeat (4) @(negedge clk);
    check("reset outputs", outs_vec(), 32'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("idle outputs", outs_vec(), 32'd0);
    init_shadow();

    for (int i = 0; i < 14; i++)
      run_frame($sformatf("vec%0d", i), tbl[i].cmd, tbl[i].addr, tbl[i].data, tbl[i].st,
                tbl[i].ms, tbl[i].nb, tbl[i].pb, tbl[i].corrupt,
                tbl[i].wr, tbl[i].val, tbl[i].ce, tbl[i].fe);

    // Reset in the middle of a 0x10 frame, csb held low through release.
    status_i = 8'h3C;
    csb = 1'b0;
    #80;
    xfer_byte(8'h10, 8, g);
    xfer_byte(8'h00, 3, g);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst outputs", outs_vec(), 32'd0);
    init_shadow();
    begin
      int w0, v0, c0, f0;
      w0 = n_wr; v0 = n_val; c0 = n_ce; f0 = n_fe;
      xfer_byte(8'hAA, 8, g);
      xfer_byte(8'h55, 8, g);
      check("midrst ignored miso_oe", 32'(miso_oe), 32'd0);
      #80;
      csb = 1'b1;
      #150;
      check("midrst no strobes", 32'((n_wr - w0) + (n_val - v0) + (n_ce - c0) + (n_fe - f0)), 32'd0);
    end
    run_frame("after_rst_f0", 8'hF0, 8'h00, 8'h00, 8'h3C, 24'h0, 2, 0, 0, 0, 1, 0, 0);

    // Random frames against the frame-rule model.
    for (int k = 0; k < 24; k++) begin
      rc  = cmd_list[$urandom_range(0, 7)];
      if (rc == 8'h77) rc = 8'($urandom);
      nb  = $urandom_range(1, 9);
      pb  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
      cor = ($urandom_range(0, 3) == 0);
      rp  = rx_pos_m(rc);
      comp = (rp != 0) && (nb > rp);
      run_frame($sformatf("rnd%0d_c%02h", k, rc), rc, 8'($urandom), 8'($urandom), 8'($urandom),
                24'($urandom), nb, pb, cor,
                comp && !cor && rc == 8'h50,
                comp && !cor && rc != 8'h50 && rc != 8'h60,
                comp && cor, !comp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
